// File: rtl/csa_resolver_if.sv
// Handshake bundle for the carry-save resolver.
// The upstream side drives the operand pair. The downstream side drives out_ready.
// The resolver owns the slave modport.
interface csa_resolver_if #(parameter int W = 5);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   s_in;
  logic [W-1:0]   c_in;
  logic           out_valid;
  logic           out_ready;
  logic [W+1:0]   y;
  logic           busy;

  modport master (
    output in_valid, s_in, c_in, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, s_in, c_in, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/csa_resolver.sv
// Bit-serial carry-propagate resolver for a (sum, carry) carry-save pair.
// It ripples one bit position per clock, so y = s + 2*c is ready W+1 cycles after acceptance.
module csa_resolver #(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  csa_resolver_if.slave  bus
);
  localparam int KW = ($clog2(W+1) < 1) ? 1 : $clog2(W+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    s_r, c_r;
  logic [W+1:0]    y_r, y_nxt;
  logic            carry;
  logic [KW-1:0]   k;
  logic            a, b, sum_bit, maj_bit, last, accept;

  // Outputs decode straight from registered state, so no input reaches an output combinationally.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.y         = y_r;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (k == KW'(W));

  // Select the operand bits for position k.
  // s[k] reads as 0 past the top bit. c[k-1] reads as 0 at bit 0, because the carry vector is pre-shifted by one.
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (k == KW'(i))   a = s_r[i];
      if (k == KW'(i+1)) b = c_r[i];
    end
  end

  assign sum_bit = a ^ b ^ carry;
  assign maj_bit = (a & b) | (a & carry) | (b & carry);

  // Write the resolved bit into position k. The last step also deposits the final carry into the top bit.
  always_comb begin
    y_nxt = y_r;
    for (int i = 0; i <= W; i++)
      if (k == KW'(i)) y_nxt[i] = sum_bit;
    if (last) y_nxt[W+1] = maj_bit;
  end

  // Next-state logic: accept only in IDLE, run W+1 steps, then hold in DONE until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s_r   <= '0;
      c_r   <= '0;
      y_r   <= '0;
      carry <= 1'b0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          s_r   <= bus.s_in;
          c_r   <= bus.c_in;
          y_r   <= '0;
          carry <= 1'b0;
          k     <= '0;
        end
        RUN: begin
          y_r   <= y_nxt;
          carry <= maj_bit;
          k     <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_resolver.sv
// Directed and table-driven bench for csa_resolver.
// A W=5 instance gets the vectors and corner sequences. A W=8 instance gets a random sweep.
module tb_csa_resolver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csa_resolver_if #(.W(5)) bus5 ();
  csa_resolver_if #(.W(8)) bus8 ();

  csa_resolver #(.W(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  csa_resolver #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [4:0] s;
    logic [4:0] c;
    int         hold;
    logic [6:0] y;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full transaction on the W=5 instance.
  // hold is the number of DONE cycles with out_ready low before the handshake.
  task automatic run5(input logic [4:0] s, input logic [4:0] c, input int hold,
                      input logic [6:0] exp, input string nm);
    int n;
    chk({nm, " in_ready_idle"}, 32'(bus5.in_ready), 1);
    bus5.in_valid = 1'b1;
    bus5.s_in     = s;
    bus5.c_in     = c;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    bus5.s_in     = 5'($urandom);
    bus5.c_in     = 5'($urandom);
    chk({nm, " busy_run"}, 32'(bus5.busy), 1);
    chk({nm, " in_ready_run"}, 32'(bus5.in_ready), 0);
    n = 0;
    while (!bus5.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 6);
    chk({nm, " y"}, 32'(bus5.y), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold_valid"}, 32'(bus5.out_valid), 1);
      chk({nm, " hold_y"}, 32'(bus5.y), 32'(exp));
    end
    bus5.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
    chk({nm, " out_valid_drop"}, 32'(bus5.out_valid), 0);
    chk({nm, " in_ready_back"}, 32'(bus5.in_ready), 1);
  endtask

  initial begin
    int n;
    logic [7:0] rs, rc;
    logic [9:0] ey;

    vecs[0] = '{5'd2,  5'd13, 0, 7'd28, "csa_example"};
    vecs[1] = '{5'd31, 5'd31, 0, 7'd93, "max_ops"};
    vecs[2] = '{5'd0,  5'd0,  0, 7'd0,  "zero_ops"};
    vecs[3] = '{5'd22, 5'd11, 3, 7'd44, "backpressure"};
    vecs[4] = '{5'd1,  5'd0,  0, 7'd1,  "s_only"};
    vecs[5] = '{5'd0,  5'd31, 0, 7'd62, "c_only"};
    vecs[6] = '{5'd31, 5'd0,  1, 7'd31, "s_max"};
    vecs[7] = '{5'd21, 5'd10, 0, 7'd41, "alt_bits"};

    bus5.in_valid = 1'b0; bus5.s_in = '0; bus5.c_in = '0; bus5.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.s_in = '0; bus8.c_in = '0; bus8.out_ready = 1'b0;

    // Reset state. in_valid is held high during reset to show that it is ignored.
    bus5.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus5.in_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst y", 32'(bus5.y), 0);
    chk("rst out_valid", 32'(bus5.out_valid), 0);
    chk("rst in_ready", 32'(bus5.in_ready), 1);
    chk("rst busy", 32'(bus5.busy), 0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      run5(vecs[i].s, vecs[i].c, vecs[i].hold, vecs[i].y, vecs[i].name);

    // A pair offered during RUN and DONE is ignored, then taken once the block is back in IDLE.
    bus5.in_valid = 1'b1; bus5.s_in = 5'd22; bus5.c_in = 5'd11;
    @(posedge clk); #1;
    n = 0;
    repeat (2) begin @(posedge clk); #1; n++; end
    bus5.s_in = 5'd31; bus5.c_in = 5'd31;
    chk("ign in_ready_run", 32'(bus5.in_ready), 0);
    while (!bus5.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("ign latency", 32'(n), 6);
    chk("ign y", 32'(bus5.y), 44);
    chk("ign in_ready_done", 32'(bus5.in_ready), 0);
    bus5.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
    chk("ign in_ready_back", 32'(bus5.in_ready), 1);
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    chk("ign second_accepted", 32'(bus5.busy), 1);
    n = 0;
    while (!bus5.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("ign2 latency", 32'(n), 6);
    chk("ign2 y", 32'(bus5.y), 93);
    bus5.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;

    // Reset lands on the edge that would process bit 2.
    bus5.in_valid = 1'b1; bus5.s_in = 5'd31; bus5.c_in = 5'd31;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst y", 32'(bus5.y), 0);
    chk("midrst out_valid", 32'(bus5.out_valid), 0);
    chk("midrst in_ready", 32'(bus5.in_ready), 1);
    chk("midrst busy", 32'(bus5.busy), 0);
    run5(5'd2, 5'd13, 0, 7'd28, "post_reset");

    // Random sweep on the W=8 instance, with random consumer stalls.
    for (int t = 0; t < 1000; t++) begin
      rs = 8'($urandom);
      rc = 8'($urandom);
      ey = 10'(rs) + 10'(rc) * 10'd2;
      bus8.in_valid = 1'b1; bus8.s_in = rs; bus8.c_in = rc;
      n = 0;
      while (!bus8.in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      n = 0;
      while (!bus8.out_valid && n < 30) begin @(posedge clk); #1; n++; end
      chk("sweep latency", 32'(n), 9);
      chk("sweep y", 32'(bus8.y), 32'(ey));
      n = 0;
      bus8.out_ready = 1'b0;
      while (!bus8.out_ready && n < 50) begin
        bus8.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      if (!bus8.out_ready) begin
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
      end
      bus8.out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
